// File: rtl/mips_pkg.sv
// mips_pkg -- constants shared by the fetch stage and the controller.
//   npc_sel_e        : 2-bit next-PC source encoding (SEQ/BR/JMP/JR)
//   RESET_PC_DEFAULT : PC after reset
//   IM_BASE_DEFAULT  : byte address of instruction-memory word 0
//   IM_DEPTH_DEFAULT : instruction-memory depth in words
package mips_pkg;

  typedef enum logic [1:0] {
    NPC_SEQ = 2'b00,
    NPC_BR  = 2'b01,
    NPC_JMP = 2'b10,
    NPC_JR  = 2'b11
  } npc_sel_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
  localparam logic [31:0] IM_BASE_DEFAULT  = 32'h0000_3000;
  localparam int          IM_DEPTH_DEFAULT = 1024;

endpackage

// File: rtl/npc_calc.sv
// npc_calc -- combinational next-PC mux and adders.
// Ports:
//   pc        in  32  current PC
//   npc_sel   in   2  next-PC source (npc_sel_e)
//   br_taken  in   1  branch condition, only used for NPC_BR
//   imm16     in  16  branch offset field
//   imm26     in  26  jump index field
//   ra        in  32  register target for jr
//   pc_plus4  out 32  pc + 4 (wraps modulo 2^32)
//   npc       out 32  candidate next PC
module npc_calc
  import mips_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [1:0]  npc_sel,
  input  logic        br_taken,
  input  logic [15:0] imm16,
  input  logic [25:0] imm26,
  input  logic [31:0] ra,
  output logic [31:0] pc_plus4,
  output logic [31:0] npc
);

  logic [31:0] br_offset;
  logic [31:0] br_target;
  logic [31:0] jmp_target;

  assign pc_plus4   = pc + 32'd4;
  // Word offset, sign-extended and scaled to bytes.
  assign br_offset  = {{14{imm16[15]}}, imm16, 2'b00};
  assign br_target  = pc_plus4 + br_offset;
  // Jump stays inside the 256 MB region of the delay-free successor.
  assign jmp_target = {pc_plus4[31:28], imm26, 2'b00};

  always_comb begin
    npc = pc_plus4;
    case (npc_sel_e'(npc_sel))
      NPC_SEQ: npc = pc_plus4;
      NPC_BR:  npc = br_taken ? br_target : pc_plus4;
      NPC_JMP: npc = jmp_target;
      NPC_JR:  npc = ra;
      default: npc = pc_plus4;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer -- fetch-stage program counter.
// Holds the architectural PC, loads the next PC on each enabled edge and
// counts retired (advancing) cycles.
// Optional feature macro: PC_RANGE_CHECK_EN -- when defined, each candidate
// next PC is checked for alignment and instruction-memory range; a bad
// target sets a sticky fault that freezes PC and counter until reset.
// Without the macro no checking is done and fault is tied 0.
// Ports:
//   clk       in   1  clock, rising edge
//   reset     in   1  asynchronous active-high reset
//   en        in   1  advance enable (0 = stall)
//   npc_sel   in   2  next-PC source
//   br_taken  in   1  branch condition
//   imm16     in  16  branch offset field
//   imm26     in  26  jump index field
//   ra        in  32  jr register target
//   pc        out 32  current PC
//   pc_plus4  out 32  pc + 4 (link value)
//   retired   out 32  count of advancing cycles
//   fault     out  1  sticky bad-target flag
module pc_sequencer
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [31:0] IM_BASE  = IM_BASE_DEFAULT,
  parameter int          IM_DEPTH = IM_DEPTH_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [1:0]  npc_sel,
  input  logic        br_taken,
  input  logic [15:0] imm16,
  input  logic [25:0] imm26,
  input  logic [31:0] ra,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] retired,
  output logic        fault
);

  logic [31:0] pc_reg;
  logic [31:0] cnt_reg;
  logic [31:0] pc_next;
  logic        advance;

  npc_calc u_npc_calc (
    .pc       (pc_reg),
    .npc_sel  (npc_sel),
    .br_taken (br_taken),
    .imm16    (imm16),
    .imm26    (imm26),
    .ra       (ra),
    .pc_plus4 (pc_plus4),
    .npc      (pc_next)
  );

`ifdef PC_RANGE_CHECK_EN
  // 33-bit limit so a memory ending at 2^32 does not wrap to 0.
  localparam logic [32:0] IM_LIMIT = {1'b0, IM_BASE} + 33'(4 * IM_DEPTH);

  logic fault_reg;
  logic target_bad;
  logic set_fault;

  assign target_bad = (pc_next[1:0] != 2'b00)
                    || (pc_next < IM_BASE)
                    || ({1'b0, pc_next} >= IM_LIMIT);
  assign advance    = en && !fault_reg && !target_bad;
  assign set_fault  = en && !fault_reg && target_bad;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fault_reg <= 1'b0;
    end else if (set_fault) begin
      fault_reg <= 1'b1;
    end
  end

  assign fault = fault_reg;
`else
  assign advance = en;
  assign fault   = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_reg  <= RESET_PC;
      cnt_reg <= 32'd0;
    end else if (advance) begin
      pc_reg  <= pc_next;
      cnt_reg <= cnt_reg + 32'd1;
    end
  end

  assign pc      = pc_reg;
  assign retired = cnt_reg;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer -- table-driven directed checks for pc_sequencer plus
// hand-written sequences for asynchronous reset and target corner cases.
module tb_pc_sequencer;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [1:0]  npc_sel;
  logic        br_taken;
  logic [15:0] imm16;
  logic [25:0] imm26;
  logic [31:0] ra;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] retired;
  logic        fault;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .npc_sel  (npc_sel),
    .br_taken (br_taken),
    .imm16    (imm16),
    .imm26    (imm26),
    .ra       (ra),
    .pc       (pc),
    .pc_plus4 (pc_plus4),
    .retired  (retired),
    .fault    (fault)
  );

  typedef struct {
    logic        en;
    logic [1:0]  sel;
    logic        bt;
    logic [15:0] i16;
    logic [25:0] i26;
    logic [31:0] ra;
    logic [31:0] pc_pre;
    logic [31:0] p4_pre;
    logic [31:0] pc_post;
    logic [31:0] ret_post;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs [NV];

  function automatic vec_t mk(logic e, logic [1:0] s, logic b, logic [15:0] i16,
                              logic [25:0] i26, logic [31:0] r, logic [31:0] pp,
                              logic [31:0] p4, logic [31:0] pn, logic [31:0] rt);
    vec_t v;
    v.en = e; v.sel = s; v.bt = b; v.i16 = i16; v.i26 = i26; v.ra = r;
    v.pc_pre = pp; v.p4_pre = p4; v.pc_post = pn; v.ret_post = rt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Called at a negedge: drive, check pre-edge values, then post-edge values.
  task automatic drive(input logic e, input logic [1:0] s, input logic b,
                       input logic [15:0] i16, input logic [25:0] i26, input logic [31:0] r);
    en = e; npc_sel = s; br_taken = b; imm16 = i16; imm26 = i26; ra = r;
  endtask

  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] ret_save;

    vecs[0]  = mk(1, NPC_SEQ, 0, 16'h0000, 26'h0,       32'h0,    32'h3000, 32'h3004, 32'h3004, 1);
    vecs[1]  = mk(1, NPC_SEQ, 0, 16'h0000, 26'h0,       32'h0,    32'h3004, 32'h3008, 32'h3008, 2);
    vecs[2]  = mk(1, NPC_SEQ, 0, 16'h0000, 26'h0,       32'h0,    32'h3008, 32'h300C, 32'h300C, 3);
    vecs[3]  = mk(1, NPC_SEQ, 0, 16'h0000, 26'h0,       32'h0,    32'h300C, 32'h3010, 32'h3010, 4);
    vecs[4]  = mk(1, NPC_BR,  1, 16'hFFFC, 26'h0,       32'h0,    32'h3010, 32'h3014, 32'h3004, 5);
    vecs[5]  = mk(1, NPC_JR,  0, 16'h0000, 26'h0,       32'h3010, 32'h3004, 32'h3008, 32'h3010, 6);
    vecs[6]  = mk(1, NPC_BR,  0, 16'hFFFC, 26'h0,       32'h0,    32'h3010, 32'h3014, 32'h3014, 7);
    vecs[7]  = mk(1, NPC_JR,  0, 16'h0000, 26'h0,       32'h3020, 32'h3014, 32'h3018, 32'h3020, 8);
    vecs[8]  = mk(1, NPC_JMP, 0, 16'h0000, 26'h0000C10, 32'h0,    32'h3020, 32'h3024, 32'h3040, 9);
    vecs[9]  = mk(1, NPC_JR,  0, 16'h0000, 26'h0,       32'h3100, 32'h3040, 32'h3044, 32'h3100, 10);
    vecs[10] = mk(0, NPC_JR,  0, 16'h0000, 26'h0,       32'h0,    32'h3100, 32'h3104, 32'h3100, 10);
    vecs[11] = mk(0, NPC_BR,  1, 16'h0040, 26'h0,       32'h0,    32'h3100, 32'h3104, 32'h3100, 10);
    vecs[12] = mk(1, NPC_BR,  1, 16'h0010, 26'h0,       32'h0,    32'h3100, 32'h3104, 32'h3144, 11);
    vecs[13] = mk(1, NPC_SEQ, 1, 16'h0010, 26'h0,       32'h0,    32'h3144, 32'h3148, 32'h3148, 12);

    reset = 1'b1;
    drive(0, NPC_SEQ, 0, 16'h0, 26'h0, 32'h0);
    #1;
    chk("reset_pc", pc, 32'h3000);
    chk("reset_pc_plus4", pc_plus4, 32'h3004);
    chk("reset_retired", retired, 32'd0);
    chk("reset_fault", {31'd0, fault}, 32'd0);
    // Enable asserted during reset must not move the PC.
    en = 1'b1;
    step();
    step();
    chk("reset_dominates_en", pc, 32'h3000);
    reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].en, vecs[i].sel, vecs[i].bt, vecs[i].i16, vecs[i].i26, vecs[i].ra);
      #1;
      chk($sformatf("v%0d_pc_pre", i), pc, vecs[i].pc_pre);
      chk($sformatf("v%0d_p4_pre", i), pc_plus4, vecs[i].p4_pre);
      step();
      chk($sformatf("v%0d_pc_post", i), pc, vecs[i].pc_post);
      chk($sformatf("v%0d_retired", i), retired, vecs[i].ret_post);
      $display("vec %0d en=%0d sel=%0d pc=%h retired=%0d", i, vecs[i].en, vecs[i].sel, pc, retired);
    end

    // Asynchronous reset between edges, mid-program.
    drive(1, NPC_SEQ, 0, 16'h0, 26'h0, 32'h0);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset_pc", pc, 32'h3000);
    chk("async_reset_retired", retired, 32'd0);
    $display("async reset pc=%h retired=%0d", pc, retired);
    @(negedge clk);
    reset = 1'b0;
    step();
    chk("restart_pc", pc, 32'h3004);
    chk("restart_retired", retired, 32'd1);
    $display("restart pc=%h retired=%0d", pc, retired);

`ifdef PC_RANGE_CHECK_EN
    // Misaligned jr target: fault, PC and counter frozen.
    drive(1, NPC_JR, 0, 16'h0, 26'h0, 32'h3102);
    step();
    chk("jr_misalign_fault", {31'd0, fault}, 32'd1);
    chk("jr_misalign_pc_hold", pc, 32'h3004);
    chk("jr_misalign_ret_hold", retired, 32'd1);
    drive(1, NPC_SEQ, 0, 16'h0, 26'h0, 32'h0);
    step();
    step();
    chk("fault_frozen_pc", pc, 32'h3004);
    chk("fault_frozen_ret", retired, 32'd1);
    chk("fault_sticky", {31'd0, fault}, 32'd1);
    $display("fault pc=%h retired=%0d fault=%0d", pc, retired, fault);
    reset = 1'b1;
    #1;
    chk("fault_reset_pc", pc, 32'h3000);
    chk("fault_reset_flag", {31'd0, fault}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    // Last word is legal; stepping past it faults.
    drive(1, NPC_JR, 0, 16'h0, 26'h0, 32'h3FFC);
    step();
    chk("last_word_pc", pc, 32'h3FFC);
    chk("last_word_fault", {31'd0, fault}, 32'd0);
    drive(1, NPC_SEQ, 0, 16'h0, 26'h0, 32'h0);
    step();
    chk("past_end_fault", {31'd0, fault}, 32'd1);
    chk("past_end_pc", pc, 32'h3FFC);
    $display("past end pc=%h fault=%0d", pc, fault);
`else
    // No checking: misaligned target loads verbatim.
    ret_save = retired;
    drive(1, NPC_JR, 0, 16'h0, 26'h0, 32'h3102);
    step();
    chk("jr_misalign_pc", pc, 32'h3102);
    chk("jr_misalign_fault", {31'd0, fault}, 32'd0);
    chk("jr_misalign_ret", retired, ret_save + 32'd1);
    $display("jr misaligned pc=%h fault=%0d", pc, fault);
    // PC+4 wraps from the top of the address space.
    drive(1, NPC_JR, 0, 16'h0, 26'h0, 32'hFFFF_FFFC);
    step();
    drive(1, NPC_SEQ, 0, 16'h0, 26'h0, 32'h0);
    #1;
    chk("wrap_p4_pre", pc_plus4, 32'h0);
    step();
    chk("wrap_pc", pc, 32'h0);
    $display("wrap pc=%h", pc);
    // Jump keeps the upper nibble of pc+4.
    drive(1, NPC_JR, 0, 16'h0, 26'h0, 32'hA000_0000);
    step();
    drive(1, NPC_JMP, 0, 16'h0, 26'h3FF_FFFF, 32'h0);
    step();
    chk("jmp_region_pc", pc, 32'hAFFF_FFFC);
    $display("jmp region pc=%h", pc);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Fetch-stage program counter for the single-cycle MIPS datapath. It holds the architectural PC and drives it to the instruction memory. Each enabled cycle it loads the next PC: sequential, taken branch, `j`/`jal` target, or `jr` register target. It also exports PC+4 for link writes and a retired-instruction counter for the testbench.

## Interface
Parameters:
- RESET_PC, 32'h0000_3000, PC value after reset.
- IM_BASE, 32'h0000_3000, byte address of instruction-memory word 0.
- IM_DEPTH, 1024, instruction-memory depth in words.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- en  in  1  advance enable; 0 holds PC and counter (stall).
- npc_sel  in  2  next-PC source: 00 SEQ, 01 BR, 10 JMP, 11 JR.
- br_taken  in  1  branch condition from the compare unit; used only when npc_sel=BR.
- imm16  in  16  branch offset field of the current instruction.
- imm26  in  26  jump index field of the current instruction.
- ra  in  32  GPR[rs] value for `jr`.
- pc  out  32  current PC; goes to instruction memory.
- pc_plus4  out  32  pc+4, combinational; used as the `jal` link value.
- retired  out  32  count of cycles in which PC advanced.
- fault  out  1  sticky bad-target flag; exists only under PC_RANGE_CHECK_EN, otherwise tied 0.

## Operation
- State: pc_q (32), cnt_q (32), fault_q (1).
- Next PC selection, all arithmetic modulo 2^32:
  - SEQ: pc+4.
  - BR, br_taken=1: pc+4 + (sign-extended imm16 << 2).
  - BR, br_taken=0: pc+4.
  - JMP: {pc_plus4[31:28], imm26, 2'b00}.
  - JR: ra, taken verbatim.
- Update on an edge with en=1: pc_q <= next PC, cnt_q <= cnt_q+1.
  - cnt_q wraps from 32'hFFFF_FFFF to 0.
  - pc+4 from 32'hFFFF_FFFC wraps to 0.
- Update on an edge with en=0: pc_q and cnt_q hold. npc_sel, br_taken, imm16, imm26 and ra are ignored.
- Fault mode: fault_q=1 freezes pc_q and cnt_q regardless of en, until reset.

## Timing
- Reset, asserted asynchronously and effective immediately: pc=RESET_PC, retired=0, fault=0. pc_plus4 therefore reads RESET_PC+4.
- Reset dominates en. Deassertion mid-stream restarts at RESET_PC on the first rising edge with reset low and en=1.
- Latency: a new PC is visible one cycle after the edge that sampled the control inputs. The instruction memory output follows combinationally in the same cycle.
- pc_plus4 and the next-PC logic are purely combinational from pc_q and the inputs. There is no extra cycle, no branch delay slot, and no prediction.
- Inputs must be stable during the setup window before the edge. No handshake is used beyond en.

## Configuration
- PC_RANGE_CHECK_EN defined:
  - The candidate next PC is checked on each enabled edge.
  - It is a fault if low 2 bits ≠ 00, or it lies outside [IM_BASE, IM_BASE + 4·IM_DEPTH).
  - On a fault: pc_q holds the offending instruction's PC, cnt_q does not increment, and fault_q is set.
  - fault is sticky and cleared only by reset.
  - A SEQ step from the last word (IM_BASE + 4·IM_DEPTH − 4) is a fault.
- PC_RANGE_CHECK_EN undefined:
  - No checking is done, and fault is a constant 0.
  - Any value is loaded, including a misaligned `jr` target; the memory indexes pc[11:2] and ignores the low bits.

## Structure
- Shared package `mips_pkg` holds:
  - NPC_SEQ / NPC_BR / NPC_JMP / NPC_JR 2-bit encodings, shared with the controller.
  - RESET_PC_DEFAULT and IM_BASE_DEFAULT constants.
- One sub-module, `npc_calc`, is the natural split: a combinational next-PC mux plus adders. pc_sequencer keeps only the registers, the counter and the fault logic.

## Test plan
- Reset, then 3 cycles of SEQ with en=1 → pc = 3000, 3004, 3008, 300C; retired = 3.
- pc=0x3010, BR, br_taken=1, imm16=0xFFFC → next pc=0x3004. With br_taken=0 → next pc=0x3014.
- pc=0x3020, JMP, imm26=0x0000C10 → next pc=0x0000_3040, and pc_plus4 before the edge = 0x3024.
- JR with ra=0x3100 → pc=0x3100. Then en=0 for 2 cycles → pc stays 0x3100 and retired is unchanged.
- Under PC_RANGE_CHECK_EN: JR with ra=0x3102 → fault=1 and pc holds. Further enabled cycles keep pc frozen. Reset → pc=0x3000, fault=0.
- Assert reset asynchronously between edges mid-program → pc becomes 0x3000 and retired 0 before the next edge.
